round_robin_arbiter: RTL and testbench

//   Parametrised N-way arbiter with registered one-hot grant, grant hold and round-robin fairness.
//   - A requester keeps its grant while it keeps requesting, up to a bounded hold time.
//   - New grants go to the next requester after the last winner, so no requester starves.
//   - Sits in front of shared resources (bus masters, shared memory ports, output muxes).
//   - Supersedes the fixed-priority arbiter for any Count.
//

---
 rtl/round_robin_arbiter_if.sv | 26 ++
 rtl/round_robin_arbiter.sv | 122 ++++++++++++
 tb/tb_round_robin_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
// Grant width and index width follow the requester count.
interface round_robin_arbiter_if #(
    parameter int unsigned Count = 4
);
    localparam int unsigned IdxW = (Count > 1) ? $clog2(Count) : 1;

    logic [Count-1:0] requests;
    logic [Count-1:0] grant;
    logic [IdxW-1:0]  grant_idx;
    logic             grant_valid;

    modport master (
        output requests,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  requests,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// N-way arbiter with registered one-hot grant, bounded grant hold and round-robin fairness.
// The grant is a pure function of the previous cycle's requests and state.
module round_robin_arbiter #(
    parameter int unsigned Count   = 4,
    parameter int unsigned MaxHold = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    round_robin_arbiter_if.slave         arb_if
);
    localparam int unsigned IdxW    = (Count > 1) ? $clog2(Count) : 1;
    localparam int unsigned HoldW   = (MaxHold > 1) ? $clog2(MaxHold) : 1;
    localparam int unsigned HoldLim = (MaxHold > 0) ? MaxHold - 1 : 0;
    localparam logic [HoldW-1:0] HoldLimW = HoldW'(HoldLim);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(Count - 1);

    logic [Count-1:0] r_grant;
    logic [IdxW-1:0]  r_grant_idx;
    logic [IdxW-1:0]  r_ptr;
    logic [HoldW-1:0] r_hold_cnt;

    logic [Count-1:0] w_req;
    logic [Count-1:0] w_cand;
    logic             w_hold_ok;
    logic             w_keep;
    logic             w_hi_found;
    logic             w_lo_found;
    logic [IdxW-1:0]  w_hi_idx;
    logic [IdxW-1:0]  w_lo_idx;
    logic             w_win_found;
    logic [IdxW-1:0]  w_win_idx;
    logic [Count-1:0] w_win_onehot;
    logic [IdxW-1:0]  w_ptr_inc;

    logic [Count-1:0] w_grant_nxt;
    logic [IdxW-1:0]  w_grant_idx_nxt;
    logic [IdxW-1:0]  w_ptr_nxt;
    logic [HoldW-1:0] w_hold_cnt_nxt;

    assign w_req  = arb_if.requests;
    assign w_cand = w_req & ~r_grant;

    // Holding past the limit is only refused when someone else is actually waiting.
    assign w_hold_ok = (MaxHold == 0) || (r_hold_cnt < HoldLimW) || (w_req == r_grant);
    assign w_keep    = (|(w_req & r_grant)) && w_hold_ok;

    // Two-pass priority search: indices at or above ptr first, then the wrapped lower part.
    // Descending iteration leaves the lowest qualifying index in each pass.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = int'(Count) - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                if (i >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IdxW'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = IdxW'(i);
                end
            end
        end
    end

    assign w_win_found  = w_hi_found | w_lo_found;
    assign w_win_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_win_onehot = w_win_found ? (Count'(1) << w_win_idx) : '0;
    assign w_ptr_inc    = (w_win_idx == LastIdx) ? '0 : w_win_idx + 1'b1;

    always_comb begin
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_ptr_nxt       = r_ptr;
        w_hold_cnt_nxt  = r_hold_cnt;
        if (!(|w_req)) begin
            w_grant_nxt     = '0;
            w_grant_idx_nxt = '0;
        end else if (w_keep) begin
            if (r_hold_cnt < HoldLimW) begin
                w_hold_cnt_nxt = r_hold_cnt + 1'b1;
            end
        end else begin
            w_grant_nxt     = w_win_onehot;
            w_grant_idx_nxt = w_win_found ? w_win_idx : '0;
            w_ptr_nxt       = w_win_found ? w_ptr_inc : r_ptr;
            w_hold_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

    assign arb_if.grant       = r_grant;
    assign arb_if.grant_idx   = r_grant_idx;
    assign arb_if.grant_valid = |r_grant;

`ifndef SYNTHESIS
    a_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(r_grant));

    a_subset : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ##1 ((r_grant & ~$past(w_req)) == '0));

    a_idx_match : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|r_grant) ? (r_grant == (Count'(1) << r_grant_idx)) : (r_grant_idx == '0));

    a_hold_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_hold_cnt <= HoldLimW);
`endif
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench: a table of {requests, expected grant} cycles plus hand-written reset,
// hold-reset and pointer sequences, and a single-requester instance.
module tb_round_robin_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    round_robin_arbiter_if #(.Count(4)) bus4 ();
    round_robin_arbiter_if #(.Count(1)) bus1 ();

    round_robin_arbiter #(.Count(4), .MaxHold(4)) u_dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .arb_if (bus4)
    );

    round_robin_arbiter #(.Count(1), .MaxHold(4)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .arb_if (bus1)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic [3:0] req, input logic [3:0] exp, input int n);
        vec_t v;
        v.req = req;
        v.exp = exp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] got_g, input logic [1:0] got_i,
                         input logic got_v, input logic [3:0] exp_g);
        logic [1:0] exp_i;
        logic       exp_v;
        exp_i = '0;
        for (int i = 0; i < 4; i++) if (exp_g[i]) exp_i = 2'(i);
        exp_v = |exp_g;
        n_vec++;
        if (got_g !== exp_g || got_i !== exp_i || got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: grant=%b idx=%0d valid=%b, expected grant=%b idx=%0d valid=%b",
                     name, got_g, got_i, got_v, exp_g, exp_i, exp_v);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] exp_g);
        check(name, bus4.grant, bus4.grant_idx, bus4.grant_valid, exp_g);
    endtask

    task automatic step4(input string name, input logic [3:0] req, input logic [3:0] exp_g);
        bus4.requests = req;
        @(posedge clk);
        #1;
        check4(name, exp_g);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus4.requests = '0;
        bus1.requests = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Grant idx 2, let it reach hold_cnt=1, then switch requests to 4'b0001.
    task automatic t5_prefix(input string name);
        do_reset();
        step4({name, "_g2a"}, 4'b0100, 4'b0100);
        step4({name, "_g2b"}, 4'b0100, 4'b0100);
        step4({name, "_sw0"}, 4'b0001, 4'b0001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat1;

        rst_n         = 1'b0;
        bus4.requests = '0;
        bus1.requests = '0;
        repeat (2) @(posedge clk);
        #1;
        check4("reset_state", 4'b0000);
        rst_n = 1'b1;

        // Continuous stream from reset: ptr=0, hold_cnt=0.
        add(4'b0000, 4'b0000, 3);
        add(4'b1111, 4'b0001, 4);
        add(4'b1111, 4'b0010, 4);
        add(4'b1111, 4'b0100, 4);
        add(4'b1111, 4'b1000, 4);
        add(4'b1111, 4'b0001, 4);
        add(4'b0000, 4'b0000, 1);
        add(4'b1010, 4'b0010, 4);
        add(4'b1010, 4'b1000, 4);
        add(4'b1010, 4'b0010, 1);
        add(4'b0000, 4'b0000, 1);
        add(4'b0100, 4'b0100, 20);
        add(4'b1111, 4'b1000, 4);
        add(4'b1111, 4'b0001, 4);

        foreach (vecs[k]) begin
            step4($sformatf("vec%0d", k), vecs[k].req, vecs[k].exp);
        end

        // Dropping to 4'b0001 moves ptr to 1: 4'b1010 must then go to idx 1, not idx 3.
        t5_prefix("ptr");
        step4("ptr_after_switch", 4'b1010, 4'b0010);

        // The new grant starts with hold_cnt=0, so it is held a full 4 cycles.
        t5_prefix("hold");
        step4("hold_c2", 4'b0011, 4'b0001);
        step4("hold_c3", 4'b0011, 4'b0001);
        step4("hold_c4", 4'b0011, 4'b0001);
        step4("hold_rotate", 4'b0011, 4'b0010);

        // Asynchronous reset mid-grant, then restart from index 0.
        do_reset();
        step4("mid_g0", 4'b1111, 4'b0001);
        step4("mid_g0b", 4'b1111, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check4("async_reset_clear", 4'b0000);
        bus4.requests = 4'b1001;
        @(posedge clk);
        #1;
        check4("reset_held", 4'b0000);
        rst_n = 1'b1;
        step4("restart_idx0", 4'b1001, 4'b0001);

        // Single requester: grant is requests delayed one cycle, no hold limit.
        do_reset();
        pat1 = 10'b01_0111_1111;
        for (int k = 0; k < 10; k++) begin
            bus1.requests = pat1[k];
            @(posedge clk);
            #1;
            check($sformatf("count1_%0d", k), {3'b000, bus1.grant}, {1'b0, bus1.grant_idx},
                  bus1.grant_valid, {3'b000, pat1[k]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
